matching_table: RTL and testbench
=================================

Name: matching_table

Overview:
- Content-addressed table of SLOTS values with per-slot valid bits. It is the write/allocate side of the match path.
- Producers insert values, and the block allocates the lowest free slot and returns its index.
- Consumers remove entries by index and look up values by content.
- Internal lookup reuses matching_encoder combinationally. The result is registered to give a 1-cycle lookup response.

Parameters:
- INDEX_WIDTH, 2, width of slot index.
- VALUE_WIDTH, 4, width of stored value.
- SLOTS, 1<<INDEX_WIDTH, number of slots (derived, do not override).

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- insert_valid  in  1  insert request.
- insert_value  in  VALUE_WIDTH  value to insert.
- insert_ready  out  1  high when an insert can be accepted (= !full).
- insert_done  out  1  1-cycle pulse, cycle after an accepted insert.
- insert_index  out  INDEX_WIDTH  slot written (or existing slot on duplicate), valid with insert_done.
- insert_dup  out  1  with insert_done: value already present, no new slot used.
- remove_valid  in  1  remove request.
- remove_index  in  INDEX_WIDTH  slot to invalidate.
- lookup_valid  in  1  lookup request.
- lookup_value  in  VALUE_WIDTH  value to search.
- lookup_done  out  1  1-cycle pulse, cycle after lookup_valid.
- lookup_match  out  1  value found in a valid slot, valid with lookup_done.
- lookup_index  out  INDEX_WIDTH  matching slot (highest matching index), valid with lookup_done.
- count  out  INDEX_WIDTH+1  number of valid slots.
- full  out  1  count == SLOTS.
- empty  out  1  count == 0.

Behaviour:
- Reset (async assert, sync release):
  - all valid bits 0, values 0, count 0.
  - empty=1, full=0, insert_ready=1.
  - all done/match/dup outputs 0, indices 0.
- Accept rules:
  - An insert is accepted on the rising edge when insert_valid && insert_ready.
  - insert_ready is combinational from registered state only (no dependency on same-cycle remove).
  - When full, inserts stall even if a remove occurs in the same cycle.
- Duplicate check:
  - Compare against the pre-edge valid set, excluding remove_index when remove_valid is high in the same cycle.
  - On a hit, no slot is written and count is unchanged. insert_dup=1 and insert_index=existing slot, next cycle.
- Allocation:
  - Lowest-index slot that is free in the pre-edge valid set.
  - A slot freed by a same-cycle remove is not reused until the next cycle.
  - The value and valid bit are written at the edge. insert_done, insert_index and insert_dup=0 appear in the following cycle.
- Remove:
  - Clears valid[remove_index] at the edge. The stored value is left as is.
  - Removing an already-invalid slot is a no-op: no count change, no error.
- Count update: count_next = count + (insert allocated) − (remove of a valid slot). Simultaneous insert and remove leaves count unchanged.
- Lookup:
  - Searches the pre-edge state (a same-cycle insert/remove is not visible).
  - Registered result: lookup_done/match/index next cycle.
  - If there is no match, lookup_match=0 and lookup_index=0.
  - Lookups may issue every cycle, fully pipelined at 1 per cycle.
- Done pulses: insert_done and lookup_done are high exactly one cycle per accepted request, with no holding.
- Reset mid-operation: any pending responses are dropped, and the table empties immediately.

Decomposition:
- Shared package: INDEX_WIDTH/VALUE_WIDTH defaults, SLOTS derivation, count width.
- Sub-module: matching_encoder, used twice.
  - Lookup port: array_valids = valid bits.
  - Duplicate check: array_valids = valid bits with the removed slot masked.
- Free-slot priority encoder is inline logic (lowest free index).

Test Plan:
- Reset, then insert 4'h1, 4'h2, 4'h3, 4'h4 on back-to-back cycles:
  - insert_index 0,1,2,3 each cycle after acceptance.
  - After the last insert: full=1, count=4, insert_ready=0.
- Lookup 4'h3 on a full table:
  - next cycle: lookup_done=1, lookup_match=1, lookup_index=2.
  - lookup 4'h0: lookup_match=0.
- Duplicate: table {1,2} in slots 0,1; insert 4'h2:
  - insert_done=1, insert_dup=1, insert_index=1, count stays 2.
- Full table, remove slot 1 and insert 4'h9 in the same cycle:
  - insert not accepted (ready=0). Next cycle count=3, ready=1.
  - Retry 4'h9 → insert_index=1.
- Table {A,B,C} in slots 0–2; remove slot 0 and insert 4'hD in the same cycle:
  - D allocated to slot 3 (slot 0 not reused), count stays 3.
  - A lookup in that same cycle for 4'hA still matches index 0.
- Remove an invalid slot 2 on an empty table:
  - count stays 0, empty=1.
- Assert reset mid-stream with a lookup pending:
  - no lookup_done pulse, all outputs at reset values.

Source files
------------

// File: rtl/matching_table_pkg.sv
// -----------------------------------------------------------------------------
// matching_table_pkg
// Shared constants and helpers for the matching table and its encoder.
//   DEFAULT_INDEX_WIDTH : default width of a slot index
//   DEFAULT_VALUE_WIDTH : default width of a stored value
//   slots_for()         : number of slots for a given index width
//   count_width_for()   : width needed to hold 0..SLOTS inclusive
// -----------------------------------------------------------------------------
package matching_table_pkg;

  localparam int DEFAULT_INDEX_WIDTH = 2;
  localparam int DEFAULT_VALUE_WIDTH = 4;

  function automatic int slots_for(input int index_width);
    return 1 << index_width;
  endfunction

  // One extra bit so that a completely full table is representable.
  function automatic int count_width_for(input int index_width);
    return index_width + 1;
  endfunction

endpackage

// File: rtl/matching_table_encoder.sv
// -----------------------------------------------------------------------------
// matching_encoder
// Purely combinational content search over the table contents.
// Ports:
//   array_values : all stored values, slot i at [i]
//   array_valids : per-slot qualifier; only set slots take part in the search
//   search_value : value being looked for
//   match        : at least one qualified slot holds search_value
//   index        : highest qualified slot holding search_value (0 if none)
// -----------------------------------------------------------------------------
module matching_encoder
  import matching_table_pkg::*;
#(
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
  localparam int SLOTS = slots_for(INDEX_WIDTH)
) (
  input  logic [SLOTS-1:0][VALUE_WIDTH-1:0] array_values,
  input  logic [SLOTS-1:0]                  array_valids,
  input  logic [VALUE_WIDTH-1:0]            search_value,
  output logic                              match,
  output logic [INDEX_WIDTH-1:0]            index
);

  // Ascending scan: a later hit overwrites an earlier one, so the highest
  // matching slot wins.
  always_comb begin
    match = 1'b0;
    index = '0;
    for (int i = 0; i < SLOTS; i++) begin
      if (array_valids[i] && (array_values[i] == search_value)) begin
        match = 1'b1;
        index = INDEX_WIDTH'(i);
      end
    end
  end

endmodule

// File: rtl/matching_table.sv
// -----------------------------------------------------------------------------
// matching_table
// Content-addressed table of SLOTS values with per-slot valid bits.
// Inserts allocate the lowest free slot (or report an existing duplicate),
// removes invalidate a slot by index, lookups search by content and answer
// one cycle later.
// Ports:
//   clock, reset                  : rising-edge clock, async active-low reset
//   insert_valid / insert_value   : insert request
//   insert_ready                  : insert can be accepted (table not full)
//   insert_done / insert_index /
//   insert_dup                    : insert response, one cycle after accept
//   remove_valid / remove_index   : invalidate a slot
//   lookup_valid / lookup_value   : content search request
//   lookup_done / lookup_match /
//   lookup_index                  : lookup response, one cycle later
//   count / full / empty          : occupancy status
// -----------------------------------------------------------------------------
module matching_table
  import matching_table_pkg::*;
#(
  parameter int INDEX_WIDTH = DEFAULT_INDEX_WIDTH,
  parameter int VALUE_WIDTH = DEFAULT_VALUE_WIDTH,
  localparam int SLOTS       = slots_for(INDEX_WIDTH),
  localparam int COUNT_WIDTH = count_width_for(INDEX_WIDTH)
) (
  input  logic                   clock,
  input  logic                   reset,

  input  logic                   insert_valid,
  input  logic [VALUE_WIDTH-1:0] insert_value,
  output logic                   insert_ready,
  output logic                   insert_done,
  output logic [INDEX_WIDTH-1:0] insert_index,
  output logic                   insert_dup,

  input  logic                   remove_valid,
  input  logic [INDEX_WIDTH-1:0] remove_index,

  input  logic                   lookup_valid,
  input  logic [VALUE_WIDTH-1:0] lookup_value,
  output logic                   lookup_done,
  output logic                   lookup_match,
  output logic [INDEX_WIDTH-1:0] lookup_index,

  output logic [COUNT_WIDTH-1:0] count,
  output logic                   full,
  output logic                   empty
);

  // ---------------------------------------------------------------------------
  // Table storage
  // ---------------------------------------------------------------------------
  logic [SLOTS-1:0]                  valid;
  logic [SLOTS-1:0][VALUE_WIDTH-1:0] values;

  // ---------------------------------------------------------------------------
  // Status, all derived from registered state only so that insert_ready never
  // depends on a same-cycle remove.
  // ---------------------------------------------------------------------------
  assign full         = (count == COUNT_WIDTH'(SLOTS));
  assign empty        = (count == '0);
  assign insert_ready = !full;

  // ---------------------------------------------------------------------------
  // Remove decode. A remove of an already-invalid slot produces no hit, so it
  // cannot disturb the count.
  // ---------------------------------------------------------------------------
  logic [SLOTS-1:0] remove_mask;
  logic             remove_hit;

  assign remove_mask = remove_valid ? (SLOTS'(1) << remove_index) : '0;
  assign remove_hit  = |(valid & remove_mask);

  // ---------------------------------------------------------------------------
  // Duplicate search: a slot being removed this cycle no longer counts as
  // holding its value.
  // ---------------------------------------------------------------------------
  logic [SLOTS-1:0]       dup_valids;
  logic                   dup_match;
  logic [INDEX_WIDTH-1:0] dup_index;

  assign dup_valids = valid & ~remove_mask;

  matching_encoder #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .VALUE_WIDTH (VALUE_WIDTH)
  ) dup_encoder (
    .array_values (values),
    .array_valids (dup_valids),
    .search_value (insert_value),
    .match        (dup_match),
    .index        (dup_index)
  );

  // ---------------------------------------------------------------------------
  // Lookup search over the pre-edge table.
  // ---------------------------------------------------------------------------
  logic                   search_match;
  logic [INDEX_WIDTH-1:0] search_index;

  matching_encoder #(
    .INDEX_WIDTH (INDEX_WIDTH),
    .VALUE_WIDTH (VALUE_WIDTH)
  ) lookup_encoder (
    .array_values (values),
    .array_valids (valid),
    .search_value (lookup_value),
    .match        (search_match),
    .index        (search_index)
  );

  // ---------------------------------------------------------------------------
  // Lowest free slot. Uses the pre-edge valid set, so a slot freed by a
  // same-cycle remove is only reusable from the next cycle on. Descending
  // scan so that the lowest free slot is the last one written.
  // ---------------------------------------------------------------------------
  logic                   free_found;
  logic [INDEX_WIDTH-1:0] free_index;

  always_comb begin
    free_found = 1'b0;
    free_index = '0;
    for (int i = SLOTS - 1; i >= 0; i--) begin
      if (!valid[i]) begin
        free_found = 1'b1;
        free_index = INDEX_WIDTH'(i);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Insert decision and next-state terms. free_found is always true when the
  // table is not full; it is kept in the term so a slot is never written
  // without a free position.
  // ---------------------------------------------------------------------------
  logic                   insert_accept;
  logic                   insert_alloc;
  logic [SLOTS-1:0]       alloc_mask;
  logic [COUNT_WIDTH-1:0] count_next;

  assign insert_accept = insert_valid && insert_ready;
  assign insert_alloc  = insert_accept && !dup_match && free_found;
  assign alloc_mask    = insert_alloc ? (SLOTS'(1) << free_index) : '0;
  assign count_next    = count + COUNT_WIDTH'(insert_alloc)
                               - COUNT_WIDTH'(remove_hit);

  // ---------------------------------------------------------------------------
  // Table state. The clear is applied before the set; the allocated slot was
  // free before the edge, so the only overlap is a no-op remove of that same
  // slot, where the allocation must win. Removed values stay in place.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid  <= '0;
      values <= '0;
      count  <= '0;
    end else begin
      valid <= (valid & ~remove_mask) | alloc_mask;
      if (insert_alloc) begin
        values[free_index] <= insert_value;
      end
      count <= count_next;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered responses: single-cycle pulses, indices forced to zero when the
  // pulse is low so idle outputs stay quiet.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      insert_done  <= 1'b0;
      insert_dup   <= 1'b0;
      insert_index <= '0;
      lookup_done  <= 1'b0;
      lookup_match <= 1'b0;
      lookup_index <= '0;
    end else begin
      insert_done  <= insert_accept;
      insert_dup   <= insert_accept && dup_match;
      if (!insert_accept) begin
        insert_index <= '0;
      end else if (dup_match) begin
        insert_index <= dup_index;
      end else begin
        insert_index <= free_index;
      end
      lookup_done  <= lookup_valid;
      lookup_match <= lookup_valid && search_match;
      lookup_index <= (lookup_valid && search_match) ? search_index : '0;
    end
  end

endmodule

// File: tb/tb_matching_table.sv
// -----------------------------------------------------------------------------
// tb_matching_table
// Self-checking bench for matching_table with a table model kept as plain
// arrays of values and valid flags.
// -----------------------------------------------------------------------------
module tb_matching_table;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       insert_valid = 1'b0;
  logic [3:0] insert_value = '0;
  logic       insert_ready;
  logic       insert_done;
  logic [1:0] insert_index;
  logic       insert_dup;
  logic       remove_valid = 1'b0;
  logic [1:0] remove_index = '0;
  logic       lookup_valid = 1'b0;
  logic [3:0] lookup_value = '0;
  logic       lookup_done;
  logic       lookup_match;
  logic [1:0] lookup_index;
  logic [2:0] count;
  logic       full;
  logic       empty;

  always #5 clock = ~clock;

  matching_table dut (
    .clock        (clock),
    .reset        (reset),
    .insert_valid (insert_valid),
    .insert_value (insert_value),
    .insert_ready (insert_ready),
    .insert_done  (insert_done),
    .insert_index (insert_index),
    .insert_dup   (insert_dup),
    .remove_valid (remove_valid),
    .remove_index (remove_index),
    .lookup_valid (lookup_valid),
    .lookup_value (lookup_value),
    .lookup_done  (lookup_done),
    .lookup_match (lookup_match),
    .lookup_index (lookup_index),
    .count        (count),
    .full         (full),
    .empty        (empty)
  );

  int compared   = 0;
  int mismatched = 0;

  // Reference table and the responses it predicts for the current cycle.
  bit         m_valid[4];
  logic [3:0] m_value[4];
  bit         e_ins_done, e_ins_dup, e_lk_done, e_lk_match;
  logic [1:0] e_ins_idx, e_lk_idx;
  int         e_count;

  // All observable outputs in one vector:
  // {ins_done, ins_dup, ins_idx[1:0], lk_done, lk_match, lk_idx[1:0],
  //  count[2:0], full, empty, ready}
  logic [13:0] dut_vec;
  assign dut_vec = {insert_done, insert_dup, insert_index, lookup_done,
                    lookup_match, lookup_index, count, full, empty,
                    insert_ready};

  localparam logic [13:0] RESET_VEC = 14'b00_00_00_00_000_0_1_1;

  function automatic logic [13:0] exp_vec();
    return {e_ins_done, e_ins_dup, e_ins_idx, e_lk_done, e_lk_match, e_lk_idx,
            3'(e_count), (e_count == 4), (e_count == 0), (e_count < 4)};
  endfunction

  task automatic clear_model();
    for (int i = 0; i < 4; i++) begin
      m_valid[i] = 1'b0;
      m_value[i] = '0;
    end
    e_ins_done = 0; e_ins_dup = 0; e_ins_idx = '0;
    e_lk_done  = 0; e_lk_match = 0; e_lk_idx = '0;
    e_count    = 0;
  endtask

  // Drives one cycle of requests, advances the model, and returns 1 ns after
  // the clock edge with the DUT responses ready to inspect.
  task automatic applyStimulus(input logic iv, input logic [3:0] ival,
                               input logic rv, input logic [1:0] ri,
                               input logic lv, input logic [3:0] lval);
    int  used;
    bit  accept, dup, alloc;
    int  slot;
    used = 0;
    for (int i = 0; i < 4; i++) used += m_valid[i] ? 1 : 0;

    e_lk_done = lv; e_lk_match = 0; e_lk_idx = '0;
    if (lv) begin
      for (int i = 0; i < 4; i++)
        if (m_valid[i] && m_value[i] == lval) begin
          e_lk_match = 1; e_lk_idx = 2'(i);
        end
    end

    accept = iv && (used < 4);
    dup = 0; alloc = 0; slot = 0;
    e_ins_done = accept; e_ins_dup = 0; e_ins_idx = '0;
    if (accept) begin
      for (int i = 0; i < 4; i++)
        if (m_valid[i] && !(rv && ri == 2'(i)) && m_value[i] == ival) begin
          dup = 1; e_ins_idx = 2'(i);
        end
      if (dup) begin
        e_ins_dup = 1;
      end else begin
        for (int i = 0; i < 4; i++)
          if (!m_valid[i] && !alloc) begin
            alloc = 1; slot = i;
          end
        e_ins_idx = 2'(slot);
      end
    end

    if (rv) m_valid[ri] = 1'b0;
    if (alloc) begin
      m_valid[slot] = 1'b1;
      m_value[slot] = ival;
    end
    e_count = 0;
    for (int i = 0; i < 4; i++) e_count += m_valid[i] ? 1 : 0;

    insert_valid = iv; insert_value = ival;
    remove_valid = rv; remove_index = ri;
    lookup_valid = lv; lookup_value = lval;
    @(posedge clock);
    #1;
    insert_valid = 0; remove_valid = 0; lookup_valid = 0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    insert_valid = 0; remove_valid = 0; lookup_valid = 0;
    clear_model();
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    compared++;
    if (dut_vec !== RESET_VEC) begin
      mismatched++;
      $display("[TB] FAIL reset_state: got %b expected %b", dut_vec, RESET_VEC);
    end
  endtask

  task automatic test_fill();
    for (int k = 0; k < 4; k++) begin
      applyStimulus(1, 4'(k + 1), 0, 0, 0, 0);
      compared++;
      if ({insert_done, insert_dup, insert_index} !== {1'b1, 1'b0, 2'(k)}) begin
        mismatched++;
        $display("[TB] FAIL fill_insert%0d: got done=%b dup=%b idx=%0d expected 1/0/%0d",
                 k, insert_done, insert_dup, insert_index, k);
      end
    end
    compared++;
    if ({full, count, insert_ready} !== {1'b1, 3'd4, 1'b0}) begin
      mismatched++;
      $display("[TB] FAIL fill_full: got full=%b count=%0d ready=%b expected 1/4/0",
               full, count, insert_ready);
    end
  endtask

  task automatic test_lookup_full();
    applyStimulus(0, 0, 0, 0, 1, 4'h3);
    compared++;
    if ({lookup_done, lookup_match, lookup_index} !== {1'b1, 1'b1, 2'd2}) begin
      mismatched++;
      $display("[TB] FAIL lookup_hit: got done=%b match=%b idx=%0d expected 1/1/2",
               lookup_done, lookup_match, lookup_index);
    end
    applyStimulus(0, 0, 0, 0, 1, 4'h0);
    compared++;
    if ({lookup_done, lookup_match, lookup_index} !== {1'b1, 1'b0, 2'd0}) begin
      mismatched++;
      $display("[TB] FAIL lookup_miss: got done=%b match=%b idx=%0d expected 1/0/0",
               lookup_done, lookup_match, lookup_index);
    end
  endtask

  task automatic test_full_remove_insert();
    applyStimulus(1, 4'h9, 1, 2'd1, 0, 0);
    compared++;
    if ({insert_done, count, insert_ready} !== {1'b0, 3'd3, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL full_stall: got done=%b count=%0d ready=%b expected 0/3/1",
               insert_done, count, insert_ready);
    end
    applyStimulus(1, 4'h9, 0, 0, 0, 0);
    compared++;
    if ({insert_done, insert_dup, insert_index, count} !== {1'b1, 1'b0, 2'd1, 3'd4}) begin
      mismatched++;
      $display("[TB] FAIL full_retry: got done=%b dup=%b idx=%0d count=%0d expected 1/0/1/4",
               insert_done, insert_dup, insert_index, count);
    end
  endtask

  task automatic test_dup();
    do_reset();
    applyStimulus(1, 4'h1, 0, 0, 0, 0);
    applyStimulus(1, 4'h2, 0, 0, 0, 0);
    applyStimulus(1, 4'h2, 0, 0, 0, 0);
    compared++;
    if ({insert_done, insert_dup, insert_index, count} !== {1'b1, 1'b1, 2'd1, 3'd2}) begin
      mismatched++;
      $display("[TB] FAIL dup_insert: got done=%b dup=%b idx=%0d count=%0d expected 1/1/1/2",
               insert_done, insert_dup, insert_index, count);
    end
  endtask

  task automatic test_remove_reuse();
    do_reset();
    applyStimulus(1, 4'hA, 0, 0, 0, 0);
    applyStimulus(1, 4'hB, 0, 0, 0, 0);
    applyStimulus(1, 4'hC, 0, 0, 0, 0);
    applyStimulus(1, 4'hD, 1, 2'd0, 1, 4'hA);
    compared++;
    if ({insert_done, insert_dup, insert_index, count} !== {1'b1, 1'b0, 2'd3, 3'd3}) begin
      mismatched++;
      $display("[TB] FAIL no_reuse_insert: got done=%b dup=%b idx=%0d count=%0d expected 1/0/3/3",
               insert_done, insert_dup, insert_index, count);
    end
    compared++;
    if ({lookup_done, lookup_match, lookup_index} !== {1'b1, 1'b1, 2'd0}) begin
      mismatched++;
      $display("[TB] FAIL pre_edge_lookup: got done=%b match=%b idx=%0d expected 1/1/0",
               lookup_done, lookup_match, lookup_index);
    end
  endtask

  task automatic test_remove_invalid();
    do_reset();
    applyStimulus(0, 0, 1, 2'd2, 0, 0);
    compared++;
    if ({count, empty} !== {3'd0, 1'b1}) begin
      mismatched++;
      $display("[TB] FAIL remove_invalid: got count=%0d empty=%b expected 0/1",
               count, empty);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int n = 0; n < 400; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 4'($urandom_range(0, 6)),
                    1'($urandom_range(0, 2) == 0), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 1)), 4'($urandom_range(0, 6)));
      compared++;
      if (dut_vec !== exp_vec()) begin
        mismatched++;
        $display("[TB] FAIL random_cycle%0d: got %b expected %b", n, dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    applyStimulus(1, 4'h5, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 1, 4'h5);
    compared++;
    if ({lookup_done, lookup_match} !== 2'b11) begin
      mismatched++;
      $display("[TB] FAIL midreset_pre: got done=%b match=%b expected 1/1",
               lookup_done, lookup_match);
    end
    #2;
    reset = 1'b0;
    #1;
    compared++;
    if (dut_vec !== RESET_VEC) begin
      mismatched++;
      $display("[TB] FAIL midreset_async: got %b expected %b", dut_vec, RESET_VEC);
    end
    lookup_valid = 1'b1;
    lookup_value = 4'h5;
    @(posedge clock);
    #1;
    compared++;
    if (dut_vec !== RESET_VEC) begin
      mismatched++;
      $display("[TB] FAIL midreset_held: got %b expected %b", dut_vec, RESET_VEC);
    end
    lookup_valid = 1'b0;
    clear_model();
    reset = 1'b1;
    applyStimulus(0, 0, 0, 0, 1, 4'h5);
    compared++;
    if (dut_vec !== exp_vec()) begin
      mismatched++;
      $display("[TB] FAIL midreset_after: got %b expected %b", dut_vec, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_lookup_full();
    test_full_remove_insert();
    test_dup();
    test_remove_reuse();
    test_remove_invalid();
    test_random();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
